// File: rtl/shift_add_mul_pkg.sv
// Shared types and constants for the shift_add_mul sequential multiplier.
// The package name is fixed by the surrounding datapath, not by the file name.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // The counter must hold WIDTH itself, which is one past the last step index.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_add_mul_if.sv
// Operand/product valid-ready bundle for shift_add_mul.
// The master side is the pipeline control; the slave side is the multiplier.
interface shift_add_mul_if
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/shift_add_mul_add.sv
// add_cout: purely combinational WIDTH-bit ripple-carry adder with carry-out.
// Built as an explicit full-adder chain so it maps to one carry chain.
module add_cout #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mul.sv
// shift_add_mul: multi-cycle unsigned MUL unit, one shift-and-add step per clock.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_mul
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  shift_add_mul_if.slave bus
);

  localparam int             CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplr_q,    mplr_d;
  logic [WIDTH-1:0] acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [CW-1:0]    cnt_q,     cnt_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign addend = mplr_q[0] ? mcand_q : '0;

  add_cout #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (acc_hi_q),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

`ifdef MUL_EARLY_EXIT_EN
  // With no multiplier bits left, the remaining steps would only shift right.
  logic [CW-1:0]      steps_left;
  logic [2*WIDTH-1:0] drained;

  assign steps_left = CW'(WIDTH) - cnt_q;
  assign drained    = {acc_hi_q, prod_lo_q} >> steps_left;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_hi_d  = acc_hi_q;
    prod_lo_d = prod_lo_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_d   = bus.a;
          mplr_d    = bus.b;
          acc_hi_d  = '0;
          prod_lo_d = '0;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
`ifdef MUL_EARLY_EXIT_EN
        if (mplr_q == '0) begin
          {acc_hi_d, prod_lo_d} = drained;
          state_d               = S_DONE;
        end else begin
`else
        begin
`endif
          // Carry-out becomes the new top bit; the sum's LSB retires into prod_lo.
          acc_hi_d  = {cout, sum[WIDTH-1:1]};
          prod_lo_d = {sum[0], prod_lo_q[WIDTH-1:1]};
          mplr_d    = mplr_q >> 1;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_hi_q  <= '0;
      prod_lo_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_hi_q  <= acc_hi_d;
      prod_lo_q <= prod_lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.product   = {acc_hi_q, prod_lo_q};

endmodule

// File: doc/shift_add_mul.md
# shift_add_mul

- Sequential unsigned multiplier that reuses one WIDTH-bit ripple adder across iterations: a controller FSM steps it through one shift-and-add step per clock to form a 2*WIDTH-bit product.
- Sits beside the ALU in the lab datapath as the multi-cycle MUL unit.
- Uses valid/ready handshakes on both sides so the pipeline control can stall around it.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64; counter width is $clog2(WIDTH)+1.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product available; high only in DONE.
- out_ready  input  1  consumer takes product.
- product  output  2*WIDTH  a*b, unsigned, exact (no overflow possible).

## Operation
- Registers:
  - mcand (WIDTH), mplr (WIDTH), acc_hi (WIDTH), prod_lo (WIDTH) and cnt.
  - product = {acc_hi, prod_lo}.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch mcand<=a, mplr<=b, acc_hi<=0, prod_lo<=0, cnt<=0, then go to RUN.
  - RUN: once per cycle, {c,s} = acc_hi + (mplr[0] ? mcand : 0) through the adder sub-module (WIDTH-bit sum plus carry-out). Then acc_hi<={c,s[WIDTH-1:1]}, prod_lo<={s[0],prod_lo[WIDTH-1:1]}, mplr<=mplr>>1, cnt<=cnt+1. Go to DONE when this step has cnt==WIDTH-1.
  - DONE: out_valid=1. On out_ready, go to IDLE; no other register changes.
- DONE does not accept new operands in the same cycle. A new accept is possible at the earliest one cycle after the output handshake.
- Operand values on a/b are ignored outside the IDLE accept cycle.
- Product is held stable while out_valid && !out_ready.
- in_valid while the block is busy is ignored; the upstream holds it until in_ready.

## Timing
- Reset (async assert, clock-synchronous release of effect):
  - state=IDLE, in_ready=1, out_valid=0, product=0, cnt=0, mplr=0, mcand=0.
- Reset asserted mid-RUN or in DONE:
  - Any in-flight operation is discarded immediately; no product is produced.
- Latency without early exit: the accept edge is E0. RUN occupies the edges E1..EWIDTH, and out_valid rises after EWIDTH, so latency is WIDTH cycles for all operands.
- Throughput: one product per WIDTH+2 cycles with out_ready held high (accept, WIDTH steps, handshake).
- Adder path: single combinational pass per cycle; no registers inside the adder.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - A RUN cycle that sees mplr==0 with cnt=k<WIDTH finishes at once.
  - It loads {acc_hi,prod_lo} <= {acc_hi,prod_lo} >> (WIDTH-k) (logical shift) and goes to DONE.
  - Latency = 1 if b==0, else min(WIDTH, msb_index(b)+2).
- MUL_EARLY_EXIT_EN undefined:
  - Fixed WIDTH-cycle latency, no barrel shifter synthesized.
- In both modes, product values are bit-identical.

## Structure
- Package mul_seq_pkg holds:
  - the state enum (S_IDLE, S_RUN, S_DONE);
  - the default WIDTH constant;
  - a cnt-width function.
- Sub-module add_cout:
  - WIDTH-bit combinational adder with carry-out, instantiated once.
  - It is the only adder in the block.
- Controller FSM and shift registers live in shift_add_mul.

## Test plan
- After reset, and with rst pulsed mid-RUN at cnt=10 (a=7, b=9):
  - in_ready=1, out_valid=0, product=0.
  - After rst releases, no out_valid appears; the next operands compute normally.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, out_ready=1:
  - product=64'hFFFF_FFFE_0000_0001.
  - out_valid exactly 32 cycles after the accept edge.
- a=12345, b=0 and a=0, b=32'hDEAD_BEEF:
  - product=0.
  - With MUL_EARLY_EXIT_EN, b=0 gives out_valid 1 cycle after accept; without it, 32 cycles.
- a=6, b=7, out_ready held low for 5 cycles after out_valid:
  - product=42, held stable, in_ready=0 throughout.
  - in_ready returns 1 the cycle after out_ready is asserted.
- Back-to-back random stream of 1000 pairs, random in_valid/out_ready gaps:
  - Every product equals the a*b reference in order, with no drop and no duplicate.
- MUL_EARLY_EXIT_EN, a=3, b=1 and b=32'h8000_0000:
  - product=3 with latency 2.
  - product=64'h1_8000_0000 with latency 32.
